// File: rtl/mux_stim_pkg.sv
// Shared types and constants for the mux stimulus sequencer: FSM states,
// step count and the {A,B,S} pattern of every step.
package mux_stim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  localparam int unsigned NUM_STEPS = 5;
  localparam int unsigned STEP_W    = 3;

  // Element k is the {A,B,S} pattern driven during step k.
  localparam logic [NUM_STEPS-1:0][2:0] STEP_PAT = {
    3'b011, 3'b001, 3'b101, 3'b100, 3'b000
  };

  function automatic logic [2:0] step_pattern(input logic [STEP_W-1:0] s);
    logic [2:0] p;
    p = '0;
    if (s < STEP_W'(NUM_STEPS)) p = STEP_PAT[s];
    return p;
  endfunction

endpackage

// File: rtl/mux_stim_sequencer_tick_gen.sv
// Prescaler: while enabled, pulses tick for one cycle every TICK_DIV cycles.
// Holds its count while disabled; clr restarts the count from zero.
module tick_gen #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= tick ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/mux_stim_sequencer.sv
// Hardware stimulus source for a 2:1 mux: walks {A,B,S} through five timed
// steps after a start pulse, with pause, optional looping and status flags.
module mux_stim_sequencer
  import mux_stim_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned DWELL0   = 16,
  parameter int unsigned DWELL1   = 8,
  parameter int unsigned DWELL2   = 14,
  parameter int unsigned DWELL3   = 16,
  parameter int unsigned DWELL4   = 16,
  parameter int unsigned LOOP     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic              A,
  output logic              B,
  output logic              S,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  if (TICK_DIV == 0 || TICK_DIV > CNT_MAX || DWELL0 > CNT_MAX ||
      DWELL1 > CNT_MAX || DWELL2 > CNT_MAX || DWELL3 > CNT_MAX ||
      DWELL4 > CNT_MAX) begin : g_cfg_check
    $error("mux_stim_sequencer: TICK_DIV/DWELLk out of range for CNT_W=%0d", CNT_W);
  end

  // A zero dwell still occupies one tick so every step is visible.
  function automatic logic [CNT_W-1:0] dwell_of(input logic [STEP_W-1:0] k);
    int unsigned d;
    case (k)
      3'd0:    d = DWELL0;
      3'd1:    d = DWELL1;
      3'd2:    d = DWELL2;
      3'd3:    d = DWELL3;
      default: d = DWELL4;
    endcase
    return (d == 0) ? CNT_W'(1) : CNT_W'(d);
  endfunction

  state_t            state, state_next;
  logic [STEP_W-1:0] step_next;
  logic [CNT_W-1:0]  dwell, dwell_next;
  logic [2:0]        pat_next;
  logic              busy_next, done_next;
  logic              tick, cnt_en, cnt_clr;

  assign cnt_en  = (state == RUN || state == PAUSED) && !pause;
  assign cnt_clr = (state == IDLE || state == DONE) && start;

  tick_gen #(
    .CNT_W   (CNT_W),
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      dwell     <= '0;
      {A, B, S} <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      step      <= step_next;
      dwell     <= dwell_next;
      {A, B, S} <= pat_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // The edge that releases PAUSED also counts, so paused time is exactly the
  // number of cycles pause was high.
  always_comb begin
    state_next = state;
    step_next  = step;
    dwell_next = dwell;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          step_next  = '0;
          dwell_next = dwell_of('0);
        end
      end
      RUN, PAUSED: begin
        state_next = pause ? PAUSED : RUN;
        if (tick) begin
          if (dwell > CNT_W'(1)) begin
            dwell_next = dwell - CNT_W'(1);
          end else if (step == LAST_STEP) begin
            if (LOOP != 0) begin
              step_next  = '0;
              dwell_next = dwell_of('0);
            end else begin
              state_next = DONE;
            end
          end else begin
            step_next  = step + STEP_W'(1);
            dwell_next = dwell_of(step + STEP_W'(1));
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pat_next  = step_pattern(step_next);
    busy_next = (state_next == RUN) || (state_next == PAUSED);
    done_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_mux_stim_sequencer.sv
// Self-checking bench: three configurations driven together, compared each
// cycle against a prefix-sum timing model plus fixed checkpoint tables.
module tb_mux_stim_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;

  always #5 clk = ~clk;

  logic [2:0]      a_o, b_o, s_o, busy_o, done_o;
  logic [2:0][2:0] step_o;

  mux_stim_sequencer dut_def (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .A(a_o[0]), .B(b_o[0]), .S(s_o[0]), .step(step_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  mux_stim_sequencer #(.TICK_DIV(3), .DWELL0(2), .DWELL1(0)) dut_div (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .A(a_o[1]), .B(b_o[1]), .S(s_o[1]), .step(step_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  mux_stim_sequencer #(.LOOP(1)) dut_loop (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .A(a_o[2]), .B(b_o[2]), .S(s_o[2]), .step(step_o[2]),
    .busy(busy_o[2]), .done(done_o[2])
  );

  typedef struct {
    int         cyc;
    logic       start;
    logic [7:0] exp;   // {A,B,S, step[2:0], busy, done}
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc;

  // Reference model: mode 0 idle, 1 sequencing, 2 finished; act = counted cycles.
  int   mode [3];
  int   act [3];
  int   div_p [3];
  int   dw_p [3][5];
  bit   loop_p [3];
  logic [2:0] pat_ref [5];
  vec_t tbl [14];

  function automatic int seg_len(int i, int k);
    return ((dw_p[i][k] == 0) ? 1 : dw_p[i][k]) * div_p[i];
  endfunction

  function automatic int total_len(int i);
    int t = 0;
    for (int k = 0; k < 5; k++) t += seg_len(i, k);
    return t;
  endfunction

  function automatic int step_at(int i, int a);
    int acc = 0;
    for (int k = 0; k < 5; k++) begin
      if (a < acc + seg_len(i, k)) return k;
      acc += seg_len(i, k);
    end
    return 4;
  endfunction

  function automatic logic [7:0] expected(int i);
    int k;
    if (mode[i] == 0) return 8'b0;
    if (mode[i] == 2) return {3'b011, 3'd4, 1'b0, 1'b1};
    k = step_at(i, act[i]);
    return {pat_ref[k], 3'(k), 1'b1, 1'b0};
  endfunction

  function automatic logic [7:0] observed(int i);
    return {a_o[i], b_o[i], s_o[i], step_o[i], busy_o[i], done_o[i]};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %b exp %b", name, cyc, got, exp);
    end
  endtask

  task automatic clock_cycle();
    logic r, s, p;
    r = rst; s = start; p = pause;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        mode[i] = 0; act[i] = 0;
      end else if (mode[i] != 1) begin
        if (s) begin mode[i] = 1; act[i] = 0; end
      end else begin
        if (!p) act[i]++;
        if (act[i] == total_len(i)) begin
          if (loop_p[i]) act[i] = 0;
          else mode[i] = 2;
        end
      end
    end
    cyc++;
    for (int i = 0; i < 3; i++) check($sformatf("model%0d", i), observed(i), expected(i));
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    clock_cycle();
    clock_cycle();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    div_p  = '{1, 3, 1};
    loop_p = '{1'b0, 1'b0, 1'b1};
    dw_p[0] = '{16, 8, 14, 16, 16};
    dw_p[1] = '{2, 0, 14, 16, 16};
    dw_p[2] = '{16, 8, 14, 16, 16};
    pat_ref = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b011};
    for (int i = 0; i < 3; i++) begin mode[i] = 0; act[i] = 0; end

    tbl[0]  = '{0,  1'b1, 8'b000_000_0_0};
    tbl[1]  = '{1,  1'b0, 8'b000_000_1_0};
    tbl[2]  = '{5,  1'b1, 8'b000_000_1_0};
    tbl[3]  = '{16, 1'b0, 8'b000_000_1_0};
    tbl[4]  = '{17, 1'b0, 8'b100_001_1_0};
    tbl[5]  = '{24, 1'b0, 8'b100_001_1_0};
    tbl[6]  = '{25, 1'b0, 8'b101_010_1_0};
    tbl[7]  = '{38, 1'b0, 8'b101_010_1_0};
    tbl[8]  = '{39, 1'b0, 8'b001_011_1_0};
    tbl[9]  = '{55, 1'b0, 8'b011_100_1_0};
    tbl[10] = '{70, 1'b0, 8'b011_100_1_0};
    tbl[11] = '{71, 1'b0, 8'b011_100_0_1};
    tbl[12] = '{80, 1'b1, 8'b011_100_0_1};
    tbl[13] = '{81, 1'b0, 8'b000_000_1_0};

    do_reset();

    // Full sequence, ignored start at 5, restart from DONE at 80
    while (cyc <= 85) begin
      start = 1'b0;
      foreach (tbl[j]) begin
        if (tbl[j].cyc == cyc) begin
          check("tbl", observed(0), tbl[j].exp);
          if (tbl[j].start) start = 1'b1;
        end
      end
      if (cyc == 6)  check("div_step0_end", observed(1), 8'b000_000_1_0);
      if (cyc == 7)  check("div_step1",     observed(1), 8'b100_001_1_0);
      if (cyc == 10) check("div_zero_dwell", observed(1), 8'b101_010_1_0);
      if (cyc == 70) check("loop_last",     observed(2), 8'b011_100_1_0);
      if (cyc == 71) check("loop_wrap",     observed(2), 8'b000_000_1_0);
      clock_cycle();
    end

    // Pause during step 0 for cycles 10..19
    do_reset();
    while (cyc <= 30) begin
      if (cyc == 15) check("pause_frozen", observed(0), 8'b000_000_1_0);
      if (cyc == 26) check("pause_step0",  observed(0), 8'b000_000_1_0);
      if (cyc == 27) check("pause_step1",  observed(0), 8'b100_001_1_0);
      start = (cyc == 0);
      pause = (cyc >= 10 && cyc <= 19);
      clock_cycle();
    end

    // Start and pause together in IDLE
    do_reset();
    while (cyc <= 21) begin
      if (cyc == 1)  check("sp_started", observed(0), 8'b000_000_1_0);
      if (cyc == 19) check("sp_step0",   observed(0), 8'b000_000_1_0);
      if (cyc == 20) check("sp_step1",   observed(0), 8'b100_001_1_0);
      start = (cyc == 0);
      pause = (cyc <= 3);
      clock_cycle();
    end

    // Reset mid-sequence, then clean restart
    do_reset();
    while (cyc <= 60) begin
      if (cyc == 30) check("rst_before", observed(0), 8'b101_010_1_0);
      if (cyc == 31) check("rst_after",  observed(0), 8'b000_000_0_0);
      if (cyc == 41) check("rst_restart", observed(0), 8'b000_000_1_0);
      if (cyc == 57) check("rst_step1",  observed(0), 8'b100_001_1_0);
      rst   = (cyc == 30);
      start = (cyc == 0 || cyc == 40);
      pause = 1'b0;
      clock_cycle();
    end
    rst = 1'b0;

    // Randomized traffic against the model
    do_reset();
    repeat (3000) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 24) == 0);
      pause = ($urandom_range(0, 6) == 0);
      clock_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_stim_sequencer.md
Name: mux_stim_sequencer

Overview:
- Upstream stage of the 2:1 mux (inputs A, B, S; output Y).
- Generates the mux's A, B and S inputs in hardware as a fixed five-step timed pattern.
- Replaces hand-written delay stimulus, so the mux can be exercised on the board and in simulation from one clock.
- Started by a single-cycle start request; supports pause, optional looping and busy/done status.

Parameters:
- CNT_W, 8, width of the dwell counter and prescaler counter.
- TICK_DIV, 1, number of clk cycles per dwell tick, range 1..2^CNT_W-1.
- DWELL0, 16, ticks spent in step 0.
- DWELL1, 8, ticks spent in step 1.
- DWELL2, 14, ticks spent in step 2.
- DWELL3, 16, ticks spent in step 3.
- DWELL4, 16, ticks spent in step 4.
- LOOP, 0, 1 = return to step 0 after step 4 instead of finishing.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sequence; sampled in IDLE or DONE only.
- pause  in  1  level; freezes the prescaler and dwell counter while high in RUN.
- A  out  1  mux data input A.
- B  out  1  mux data input B.
- S  out  1  mux select.
- step  out  3  current step index, 0..4.
- busy  out  1  high in RUN and PAUSED.
- done  out  1  high in DONE.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset: state=IDLE, A=B=S=0, step=0, busy=0, done=0, counters=0. Reset wins over every other input on the same edge.
- Step patterns {A,B,S}:
  - step 0 = 000
  - step 1 = 100
  - step 2 = 101
  - step 3 = 001
  - step 4 = 011
- States: IDLE, RUN, PAUSED, DONE.
- IDLE/DONE with start=1 at edge N:
  - state=RUN, step=0, pattern 000, busy=1, done=0.
  - Dwell counter loaded with DWELL0, prescaler cleared.
  - Visible after edge N.
- RUN:
  - Prescaler counts clk cycles and emits an internal tick every TICK_DIV cycles. With TICK_DIV=1, every cycle is a tick.
  - Each tick decrements the dwell counter.
  - A tick when the count is 1 advances to the next step: step, pattern and dwell reload update on that edge.
  - Step k therefore lasts exactly DWELLk*TICK_DIV cycles.
- End of step 4:
  - LOOP=0: state=DONE, busy=0, done=1, pattern stays 011, step stays 4.
  - LOOP=1: step=0, pattern 000, busy stays 1.
- pause=1 in RUN:
  - Next edge state=PAUSED; prescaler and dwell counter hold; outputs hold.
  - pause=0 in PAUSED: next edge returns to RUN and counting resumes where it stopped. Total active cycles are unchanged; paused cycles are added.
- start in RUN or PAUSED: ignored.
- start in DONE: restarts as from IDLE.
- start and pause high together in IDLE: start taken; pause acts from the next cycle.
- DWELLk=0: treated as 1 (minimum one tick per step).
- Reset mid-sequence: next edge returns to IDLE with all reset values. No partial pattern survives.
- Arithmetic: counters are unsigned CNT_W bits. Parameters exceeding 2^CNT_W-1 are a configuration error, flagged by a simulation-time check.

Decomposition:
- Package mux_stim_pkg:
  - state enum (IDLE, RUN, PAUSED, DONE);
  - NUM_STEPS=5;
  - step-pattern constant array of 3-bit {A,B,S};
  - step index width.
- One sub-module, tick_gen:
  - prescaler with enable and clear;
  - outputs a one-cycle tick every TICK_DIV enabled cycles.
- FSM, dwell counter and output registers stay in the top module.

Test Plan:
- Defaults, start pulse at cycle 0 -> patterns 000/100/101/001/011 begin at cycles 1/17/25/39/55. done=1 and busy=0 from cycle 71. Mux Y matches A when S=0 and B when S=1 throughout.
- TICK_DIV=3, DWELL0=2, start -> step 0 held exactly 6 cycles. Every step length is DWELLk*3.
- Defaults, pause high for cycles 10..19 during step 0 -> state PAUSED, outputs frozen at 000. Step 1 begins at cycle 27 instead of 17.
- LOOP=1, start -> after step 4 returns to step 0 pattern 000 at cycle 71. busy stays 1 and done never asserts over 200 cycles.
- rst asserted at cycle 30 (step 2, pattern 101) -> next edge A=B=S=0, step=0, busy=0. Start at cycle 40 restarts cleanly at step 0.
- start pulsed at cycle 5 during RUN -> ignored, timing unchanged. Start in DONE at cycle 80 -> new sequence, done=0 at cycle 81.
